// File: rtl/con_fsm_if.sv
// Control bundle between the con_fsm sequencer (master) and the datapath/IO (slave).
// io_err exists only when IO_TIMEOUT_EN is defined.
interface con_fsm_if #(
  parameter int unsigned IR_W   = 8,
  parameter int unsigned REG_AW = 2
);
  logic              start;
  logic [IR_W-1:0]   ir;
  logic              z;
  logic              c;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              pc_ld;
  logic              pc_inc;
  logic              ir_ld;
  logic              reg_we;
  logic [REG_AW-1:0] reg_ra;
  logic [REG_AW-1:0] reg_wa;
  logic [1:0]        madd;
  logic              ram_xl;
  logic              ram_dl;
  logic              alu_m;
  logic [3:0]        alu_s;
  logic              cf_en;
  logic              zf_en;
  logic              shi_fbus;
  logic              shi_flbus;
  logic              shi_frbus;
  logic              busy;
  logic              halted;
`ifdef IO_TIMEOUT_EN
  logic              io_err;
`endif

  modport master (
    input  start, ir, z, c, in_valid, out_ready,
    output
`ifdef IO_TIMEOUT_EN
           io_err,
`endif
           in_ready, out_valid, pc_ld, pc_inc, ir_ld, reg_we, reg_ra, reg_wa, madd,
           ram_xl, ram_dl, alu_m, alu_s, cf_en, zf_en, shi_fbus, shi_flbus, shi_frbus,
           busy, halted
  );

  modport slave (
    output start, ir, z, c, in_valid, out_ready,
    input
`ifdef IO_TIMEOUT_EN
           io_err,
`endif
           in_ready, out_valid, pc_ld, pc_inc, ir_ld, reg_we, reg_ra, reg_wa, madd,
           ram_xl, ram_dl, alu_m, alu_s, cf_en, zf_en, shi_fbus, shi_flbus, shi_frbus,
           busy, halted
  );
endinterface

// File: rtl/con_fsm.sv
// Multi-cycle control sequencer: FETCH/EXEC/IO-wait/HALT with opcode decode from IR.
// Define IO_TIMEOUT_EN to abort IO waits after IO_TO cycles and raise a sticky io_err.
module con_fsm #(
  parameter int unsigned IR_W   = 8,
  parameter int unsigned REG_AW = 2,
  parameter int unsigned IO_TO  = 255
) (
  input  logic       clk,
  input  logic       rst,
  con_fsm_if.master  bus
);

  localparam logic [3:0] OpMova = 4'h1;
  localparam logic [3:0] OpMovb = 4'h2;
  localparam logic [3:0] OpMovc = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpSub  = 4'h5;
  localparam logic [3:0] OpAnd  = 4'h6;
  localparam logic [3:0] OpNot  = 4'h7;
  localparam logic [3:0] OpRsr  = 4'h8;
  localparam logic [3:0] OpRsl  = 4'h9;
  localparam logic [3:0] OpJmp  = 4'hA;
  localparam logic [3:0] OpJz   = 4'hB;
  localparam logic [3:0] OpJc   = 4'hC;
  localparam logic [3:0] OpIn   = 4'hD;
  localparam logic [3:0] OpOut  = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  // IO wait is split by direction so the handshake side is fixed at EXEC time.
  typedef enum logic [2:0] {StIdle, StFetch, StExec, StInWait, StOutWait, StHalt} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs;
  logic              taken;
  logic              hs;
  logic              tmo;

  assign op    = bus.ir[IR_W-1 -: 4];
  assign rd    = bus.ir[2*REG_AW-1 -: REG_AW];
  assign rs    = bus.ir[REG_AW-1:0];
  assign taken = (op == OpJmp) || ((op == OpJz) && bus.z) || ((op == OpJc) && bus.c);

`ifdef IO_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(IO_TO + 1);

  logic [CntW-1:0] cnt_q;
  logic            io_err_q;
  logic            io_wait;

  assign io_wait    = (state_q == StInWait) || (state_q == StOutWait);
  // cnt_q holds the IOWAIT cycles already spent, so this is the IO_TO-th wait cycle.
  assign tmo        = (cnt_q == CntW'(IO_TO - 1));
  assign bus.io_err = io_err_q;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
`ifdef IO_TIMEOUT_EN
      cnt_q    <= '0;
      io_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef IO_TIMEOUT_EN
      cnt_q    <= io_wait ? cnt_q + 1'b1 : '0;
      if (io_wait && !hs && tmo) io_err_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    hs            = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.pc_ld     = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.ir_ld     = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_ra    = '0;
    bus.reg_wa    = '0;
    bus.madd      = 2'b00;
    bus.ram_xl    = 1'b0;
    bus.ram_dl    = 1'b0;
    bus.alu_m     = 1'b0;
    bus.alu_s     = 4'h0;
    bus.cf_en     = 1'b0;
    bus.zf_en     = 1'b0;
    bus.shi_fbus  = 1'b0;
    bus.shi_flbus = 1'b0;
    bus.shi_frbus = 1'b0;
    bus.busy      = 1'b0;
    bus.halted    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) state_d = StFetch;
      end
      StFetch: begin
        bus.ram_dl = 1'b1;
        bus.ir_ld  = 1'b1;
        bus.pc_inc = 1'b1;
        bus.busy   = 1'b1;
        state_d    = StExec;
      end
      StExec: begin
        bus.busy   = 1'b1;
        bus.reg_ra = rs;
        bus.reg_wa = rd;
        bus.alu_s  = op;
        state_d    = StFetch;
        case (op)
          OpMova: begin
            bus.shi_fbus = 1'b1;
            bus.reg_we   = 1'b1;
          end
          OpMovb: begin
            bus.madd     = 2'b10;
            bus.ram_xl   = 1'b1;
            bus.shi_fbus = 1'b1;
          end
          OpMovc: begin
            bus.madd   = 2'b01;
            bus.ram_dl = 1'b1;
            bus.reg_we = 1'b1;
          end
          OpAdd, OpSub: begin
            bus.alu_m    = 1'b1;
            bus.shi_fbus = 1'b1;
            bus.reg_we   = 1'b1;
            bus.cf_en    = 1'b1;
            bus.zf_en    = 1'b1;
          end
          OpAnd, OpNot: begin
            bus.alu_m    = 1'b1;
            bus.shi_fbus = 1'b1;
            bus.reg_we   = 1'b1;
          end
          OpRsr, OpRsl: begin
            bus.alu_m     = 1'b1;
            bus.shi_frbus = (op == OpRsr);
            bus.shi_flbus = (op == OpRsl);
            bus.reg_we    = 1'b1;
            bus.cf_en     = 1'b1;
          end
          // Taken: read the target byte at PC into PC; not taken: step over it.
          OpJmp, OpJz, OpJc: begin
            bus.ram_dl = taken;
            bus.pc_ld  = taken;
            bus.pc_inc = !taken;
          end
          OpIn:    state_d = StInWait;
          OpOut:   state_d = StOutWait;
          OpHalt:  state_d = StHalt;
          default: ;
        endcase
      end
      StInWait: begin
        bus.busy     = 1'b1;
        bus.in_ready = 1'b1;
        bus.reg_wa   = rd;
        hs           = bus.in_valid;
        bus.reg_we   = hs;
        if (hs || tmo) state_d = StFetch;
      end
      StOutWait: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.alu_m     = 1'b1;
        bus.shi_fbus  = 1'b1;
        bus.reg_ra    = rs;
        hs            = bus.out_ready;
        if (hs || tmo) state_d = StFetch;
      end
      StHalt: begin
        bus.halted = 1'b1;
        if (bus.start) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_con_fsm.sv
// Self-checking bench for con_fsm: directed scenarios plus randomized run against a
// phase-level reference model. Define IO_TIMEOUT_EN to also cover the IO timeout.
module tb_con_fsm;
  localparam int unsigned IR_W   = 8;
  localparam int unsigned REG_AW = 2;
  localparam int unsigned IO_TO  = 4;
`ifdef IO_TIMEOUT_EN
  localparam int InDelay = 3;
`else
  localparam int InDelay = 5;
`endif
  localparam int OutDelay = 3;

  localparam int PIdle = 0, PFetch = 1, PExec = 2, PIn = 3, POut = 4, PHalt = 5;

  typedef struct packed {
    logic       pc_ld, pc_inc, ir_ld, reg_we;
    logic [1:0] reg_ra, reg_wa, madd;
    logic       ram_xl, ram_dl, alu_m;
    logic [3:0] alu_s;
    logic       cf_en, zf_en, shi_fbus, shi_flbus, shi_frbus;
    logic       busy, halted, in_ready, out_valid, io_err;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // Opcode property sets, bit n set means opcode n has the property.
  bit [15:0] writes_reg = 16'h03FA;
  bit [15:0] via_alu    = 16'h03F0;
  bit [15:0] via_fbus   = 16'h00F6;
  bit [15:0] sets_cf    = 16'h0330;
  bit [15:0] sets_zf    = 16'h0030;

  int m_phase = PIdle;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  always #5 clk = ~clk;

  con_fsm_if #(.IR_W(IR_W), .REG_AW(REG_AW)) bus ();

  con_fsm #(.IR_W(IR_W), .REG_AW(REG_AW), .IO_TO(IO_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic ctl_t sample();
    ctl_t o;
    o = '0;
    o.pc_ld = bus.pc_ld;         o.pc_inc = bus.pc_inc;       o.ir_ld = bus.ir_ld;
    o.reg_we = bus.reg_we;       o.reg_ra = bus.reg_ra;       o.reg_wa = bus.reg_wa;
    o.madd = bus.madd;           o.ram_xl = bus.ram_xl;       o.ram_dl = bus.ram_dl;
    o.alu_m = bus.alu_m;         o.alu_s = bus.alu_s;         o.cf_en = bus.cf_en;
    o.zf_en = bus.zf_en;         o.shi_fbus = bus.shi_fbus;   o.shi_flbus = bus.shi_flbus;
    o.shi_frbus = bus.shi_frbus; o.busy = bus.busy;           o.halted = bus.halted;
    o.in_ready = bus.in_ready;   o.out_valid = bus.out_valid;
`ifdef IO_TIMEOUT_EN
    o.io_err = bus.io_err;
`endif
    return o;
  endfunction

  function automatic ctl_t model_out();
    ctl_t       e;
    logic [3:0] op;
    logic [1:0] rd, rs;
    bit         taken;
    e  = '0;
    op = bus.ir[7:4];
    rd = bus.ir[3:2];
    rs = bus.ir[1:0];
`ifdef IO_TIMEOUT_EN
    e.io_err = m_err;
`endif
    if (m_phase == PFetch) begin
      e.ram_dl = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1; e.busy = 1'b1;
    end else if (m_phase == PExec) begin
      e.busy = 1'b1; e.reg_ra = rs; e.reg_wa = rd; e.alu_s = op;
      e.reg_we    = writes_reg[op];
      e.alu_m     = via_alu[op];
      e.shi_fbus  = via_fbus[op];
      e.cf_en     = sets_cf[op];
      e.zf_en     = sets_zf[op];
      e.shi_frbus = (op == 4'h8);
      e.shi_flbus = (op == 4'h9);
      if (op == 4'h2) begin e.madd = 2'b10; e.ram_xl = 1'b1; end
      if (op == 4'h3) begin e.madd = 2'b01; e.ram_dl = 1'b1; end
      taken = (op == 4'hA) || (op == 4'hB && bus.z) || (op == 4'hC && bus.c);
      if (op inside {4'hA, 4'hB, 4'hC}) begin
        e.pc_ld = taken; e.ram_dl = taken; e.pc_inc = !taken;
      end
    end else if (m_phase == PIn) begin
      e.busy = 1'b1; e.in_ready = 1'b1; e.reg_wa = rd; e.reg_we = bus.in_valid;
    end else if (m_phase == POut) begin
      e.busy = 1'b1; e.out_valid = 1'b1; e.alu_m = 1'b1; e.shi_fbus = 1'b1; e.reg_ra = rs;
    end else if (m_phase == PHalt) begin
      e.halted = 1'b1;
    end
    return e;
  endfunction

  task automatic m_step();
    logic [3:0] op;
    bit         done;
    op = bus.ir[7:4];
    if (rst) begin
      m_phase = PIdle; m_cnt = 0; m_err = 1'b0;
      return;
    end
    case (m_phase)
      PIdle, PHalt: if (bus.start) m_phase = PFetch;
      PFetch: m_phase = PExec;
      PExec: begin
        m_cnt   = 0;
        m_phase = (op == 4'hD) ? PIn : (op == 4'hE) ? POut : (op == 4'hF) ? PHalt : PFetch;
      end
      default: begin
        done = (m_phase == PIn) ? bus.in_valid : bus.out_ready;
        if (done) m_phase = PFetch;
        else begin
          m_cnt++;
`ifdef IO_TIMEOUT_EN
          if (m_cnt == IO_TO) begin m_phase = PFetch; m_err = 1'b1; end
`endif
        end
      end
    endcase
  endtask

  // One clock: sample DUT and model mid-cycle, then advance the model on the edge.
  task automatic cyc(output ctl_t obs, output ctl_t exp);
    @(negedge clk);
    obs = sample();
    exp = model_out();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    ctl_t o, e;
    rst = 1'b1;
    cyc(o, e);
    vectors++;
    if (o !== '0) begin
      $display("FAIL reset_outputs: got %h want 0", o); miscompares++;
    end
    rst = 1'b0;
    cyc(o, e);
    vectors++;
    if (o !== e || o.busy !== 1'b0) begin
      $display("FAIL idle_outputs: got %h want %h", o, e); miscompares++;
    end
  endtask

  task automatic test_add();
    ctl_t o, e;
    bus.start = 1'b1; bus.ir = 8'h46;
    cyc(o, e);
    bus.start = 1'b0;
    cyc(o, e);
    vectors++;
    if (o !== e || {o.ir_ld, o.pc_inc, o.ram_dl, o.busy} !== 4'b1111) begin
      $display("FAIL add_fetch: got %h want %h", o, e); miscompares++;
    end
    cyc(o, e);
    vectors++;
    if (o !== e || {o.alu_m, o.reg_we, o.cf_en, o.zf_en} !== 4'b1111 ||
        o.reg_wa !== 2'b01 || o.reg_ra !== 2'b10 || o.alu_s !== 4'h4) begin
      $display("FAIL add_exec: got %h want %h", o, e); miscompares++;
    end
  endtask

  task automatic test_branch();
    ctl_t o, e;
    bus.ir = 8'hB0; bus.z = 1'b0;
    cyc(o, e);
    cyc(o, e);
    vectors++;
    if (o !== e || o.pc_inc !== 1'b1 || o.pc_ld !== 1'b0) begin
      $display("FAIL jz_not_taken: got %h want %h", o, e); miscompares++;
    end
    bus.z = 1'b1;
    cyc(o, e);
    cyc(o, e);
    vectors++;
    if (o !== e || o.pc_ld !== 1'b1 || o.ram_dl !== 1'b1 || o.madd !== 2'b00) begin
      $display("FAIL jz_taken: got %h want %h", o, e); miscompares++;
    end
    bus.z = 1'b0;
  endtask

  task automatic test_mem();
    ctl_t o, e;
    bus.ir = 8'h2D;
    cyc(o, e);
    cyc(o, e);
    vectors++;
    if (o !== e || o.madd !== 2'b10 || o.ram_xl !== 1'b1 || o.reg_wa !== 2'b11 ||
        o.reg_ra !== 2'b01) begin
      $display("FAIL movb_exec: got %h want %h", o, e); miscompares++;
    end
    bus.ir = 8'h31;
    cyc(o, e);
    cyc(o, e);
    vectors++;
    if (o !== e || o.madd !== 2'b01 || o.ram_dl !== 1'b1 || o.reg_we !== 1'b1) begin
      $display("FAIL movc_exec: got %h want %h", o, e); miscompares++;
    end
  endtask

  task automatic test_io_in();
    ctl_t o, e;
    int   n_ready, n_we;
    bit   we_ok;
    n_ready = 0; n_we = 0; we_ok = 1'b1;
    bus.ir = 8'hD4; bus.in_valid = 1'b1;  // early valid must be ignored until IOWAIT
    cyc(o, e);
    cyc(o, e);
    for (int i = 0; i <= InDelay; i++) begin
      bus.in_valid = (i == InDelay);
      cyc(o, e);
      vectors++;
      if (o !== e) begin
        $display("FAIL in_wait_cycle%0d: got %h want %h", i, o, e); miscompares++;
      end
      n_ready += int'(o.in_ready);
      n_we    += int'(o.reg_we);
      if (o.reg_we !== (i == InDelay)) we_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (n_ready != InDelay + 1 || n_we != 1 || !we_ok) begin
      $display("FAIL in_handshake: got ready=%0d we=%0d want ready=%0d we=1", n_ready, n_we,
               InDelay + 1);
      miscompares++;
    end
    cyc(o, e);
    vectors++;
    if (o !== e || o.ir_ld !== 1'b1) begin
      $display("FAIL in_to_fetch: got %h want %h", o, e); miscompares++;
    end
  endtask

  task automatic test_io_out();
    ctl_t o, e;
    int   n_valid;
    n_valid = 0;
    bus.ir = 8'hE2;
    cyc(o, e);
    for (int i = 0; i <= OutDelay; i++) begin
      bus.out_ready = (i == OutDelay);
      cyc(o, e);
      vectors++;
      if (o !== e) begin
        $display("FAIL out_wait_cycle%0d: got %h want %h", i, o, e); miscompares++;
      end
      n_valid += int'(o.out_valid);
    end
    bus.out_ready = 1'b0;
    vectors++;
    if (n_valid != OutDelay + 1) begin
      $display("FAIL out_valid_hold: got %0d want %0d", n_valid, OutDelay + 1); miscompares++;
    end
  endtask

  task automatic test_halt();
    ctl_t o, e;
    bus.ir = 8'hF0;
    cyc(o, e);
    cyc(o, e);
    cyc(o, e);
    for (int i = 0; i < 20; i++) begin
      bus.z = 1'($urandom); bus.c = 1'($urandom); bus.in_valid = 1'($urandom);
      cyc(o, e);
      vectors++;
      if (o !== e || o.halted !== 1'b1 || o.busy !== 1'b0) begin
        $display("FAIL halt_hold%0d: got %h want %h", i, o, e); miscompares++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    cyc(o, e);
    bus.start = 1'b0; bus.ir = 8'hD4;
    cyc(o, e);
    vectors++;
    if (o !== e || o.ir_ld !== 1'b1) begin
      $display("FAIL halt_resume: got %h want %h", o, e); miscompares++;
    end
    cyc(o, e);
    cyc(o, e);
    rst = 1'b1;
    cyc(o, e);
    rst = 1'b0;
    cyc(o, e);
    vectors++;
    if (o !== '0) begin
      $display("FAIL reset_in_iowait: got %h want 0", o); miscompares++;
    end
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    ctl_t o, e;
    int   n_we;
    // Handshake on the last allowed cycle completes normally.
    bus.start = 1'b1; bus.ir = 8'hD4;
    cyc(o, e);
    bus.start = 1'b0;
    cyc(o, e);
    cyc(o, e);
    for (int i = 0; i < int'(IO_TO); i++) begin
      bus.in_valid = (i == int'(IO_TO) - 1);
      cyc(o, e);
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (o !== e || o.reg_we !== 1'b1 || o.io_err !== 1'b0) begin
      $display("FAIL tmo_hs_wins: got %h want %h", o, e); miscompares++;
    end
    cyc(o, e);
    cyc(o, e);
    n_we = 0;
    for (int i = 0; i < int'(IO_TO); i++) begin
      cyc(o, e);
      n_we += int'(o.reg_we);
    end
    cyc(o, e);
    vectors++;
    if (o !== e || o.ir_ld !== 1'b1 || o.io_err !== 1'b1 || n_we != 0) begin
      $display("FAIL tmo_abort: got %h we=%0d want %h we=0", o, n_we, e); miscompares++;
    end
    bus.ir = 8'h46;
    cyc(o, e);
    cyc(o, e);
    vectors++;
    if (o !== e || o.io_err !== 1'b1) begin
      $display("FAIL tmo_sticky: got %h want %h", o, e); miscompares++;
    end
    rst = 1'b1;
    cyc(o, e);
    rst = 1'b0;
    cyc(o, e);
    vectors++;
    if (o.io_err !== 1'b0) begin
      $display("FAIL tmo_reset_clear: got %b want 0", o.io_err); miscompares++;
    end
  endtask
`endif

  task automatic test_random();
    ctl_t o, e;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) == 0);
      // IR only changes while the sequencer is fetching or stopped.
      if (m_phase inside {PIdle, PHalt, PFetch}) bus.ir = 8'($urandom);
      bus.start     = ($urandom_range(3) == 0);
      bus.z         = 1'($urandom);
      bus.c         = 1'($urandom);
      bus.in_valid  = ($urandom_range(2) == 0);
      bus.out_ready = ($urandom_range(2) == 0);
      cyc(o, e);
      vectors++;
      if (o !== e) begin
        $display("FAIL random%0d: got %h want %h", i, o, e); miscompares++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.ir = '0; bus.z = 1'b0; bus.c = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_phase = PIdle; m_cnt = 0; m_err = 1'b0;
    #1;
    test_reset();
    test_add();
    test_branch();
    test_mem();
    test_io_in();
    test_io_out();
    test_halt();
`ifdef IO_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
